// File: rtl/adpll_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adpll_pkg
// Description : Shared definitions for the adpll and its lock detector:
//               default counter width, the phase-error sign convention and
//               the state encodings of the measurement and lock machines.
// Revision    : 1.0 - initial release
// ============================================================================
package adpll_pkg;

    // Counter width shared with the adpll's internal phase counter.
    localparam int CNT_W_DEF = 8;

    // Sign convention of the phase error: the measurement closed by a gen
    // edge means gen lagged rf (positive); closed by an rf edge, gen led
    // rf (negative).
    typedef enum logic {
        ERR_GEN_LAGS  = 1'b0,
        ERR_GEN_LEADS = 1'b1
    } err_sign_t;

    // Phase measurement machine.
    typedef enum logic [1:0] {
        MEAS_IDLE     = 2'd0,
        MEAS_WAIT_GEN = 2'd1,
        MEAS_WAIT_RF  = 2'd2
    } meas_state_t;

    // Lock qualification machine.
    typedef enum logic {
        LOCK_UNLOCKED = 1'b0,
        LOCK_LOCKED   = 1'b1
    } lock_state_t;

endpackage
`default_nettype wire

// File: rtl/adpll_lock_det_if.sv
`default_nettype none
// ============================================================================
// Module      : adpll_lock_det_if
// Description : Signal bundle between the lock detector and its environment.
//               i_rf / i_gen : reference and generated clocks (asynchronous)
//               o_err        : signed phase error, clk cycles
//               o_err_vld    : one-cycle strobe, new o_err
//               o_lock       : lock level
//               o_timeout    : one-cycle strobe, abandoned measurement
//               slave  modport: the detector
//               master modport: whatever drives the inputs and reads status
// Revision    : 1.0 - initial release
// ============================================================================
interface adpll_lock_det_if
    import adpll_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
);
    logic                    i_rf;
    logic                    i_gen;
    logic signed [CNT_W-1:0] o_err;
    logic                    o_err_vld;
    logic                    o_lock;
    logic                    o_timeout;

    modport master (
        output i_rf, i_gen,
        input  o_err, o_err_vld, o_lock, o_timeout
    );

    modport slave (
        input  i_rf, i_gen,
        output o_err, o_err_vld, o_lock, o_timeout
    );
endinterface
`default_nettype wire

// File: rtl/adpll_edge_sync.sv
`default_nettype none
// ============================================================================
// Module      : adpll_edge_sync
// Description : Two-flop synchronizer followed by a registered rising-edge
//               detector. Input edge to pulse latency is 3 clk cycles.
//               clk   : sampling clock
//               rst   : synchronous reset, active-low
//               din   : asynchronous input
//               pulse : one-cycle pulse per rising edge of din
// Revision    : 1.0 - initial release
// ============================================================================
module adpll_edge_sync (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic din,
    output logic      pulse
);
    logic r_meta;
    logic r_sync;
    logic r_prev;
    logic r_pulse;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_meta  <= 1'b0;
            r_sync  <= 1'b0;
            r_prev  <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_meta  <= din;
            r_sync  <= r_meta;
            r_prev  <= r_sync;
            r_pulse <= r_sync & ~r_prev;
        end
    end

    assign pulse = r_pulse;
endmodule
`default_nettype wire

// File: rtl/adpll_lock_det.sv
`default_nettype none
// ============================================================================
// Module      : adpll_lock_det
// Description : Phase-error monitor and lock detector for the adpll. Measures
//               the signed distance between rf and gen rising edges once per
//               reference period and qualifies lock over runs of in-window
//               measurements.
//               i_clk : system clock
//               i_rst : synchronous reset, active-low
//               bus   : slave side of adpll_lock_det_if (rf/gen in, status out)
// Revision    : 1.0 - initial release
// ============================================================================
module adpll_lock_det
    import adpll_pkg::*;
#(
    parameter int CNT_W      = CNT_W_DEF,
    parameter int WINDOW     = 2,
    parameter int LOCK_CNT   = 16,
    parameter int UNLOCK_CNT = 4,
    parameter int TIMEOUT    = 64
) (
    input  wire logic         i_clk,
    input  wire logic         i_rst,
    adpll_lock_det_if.slave   bus
);
    localparam int              c_good_w   = $clog2(LOCK_CNT + 1);
    localparam int              c_bad_w    = $clog2(UNLOCK_CNT + 1);
    localparam logic [CNT_W-1:0] c_one     = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_timeout = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] c_window  = CNT_W'(WINDOW);
    localparam logic [CNT_W-1:0] c_mag_max = {1'b0, {(CNT_W-1){1'b1}}};
    localparam logic [c_good_w-1:0] c_good_last = c_good_w'(LOCK_CNT - 1);
    localparam logic [c_bad_w-1:0]  c_bad_last  = c_bad_w'(UNLOCK_CNT - 1);

    // The counter must never reach the saturated magnitude.
    if (TIMEOUT >= (2 ** (CNT_W - 1)) - 1) begin : g_timeout_range_check
        $error("adpll_lock_det: TIMEOUT must be below 2**(CNT_W-1)-1");
    end

    logic w_e_rf;
    logic w_e_gen;

    adpll_edge_sync u_sync_rf  (.clk(i_clk), .rst(i_rst), .din(bus.i_rf),  .pulse(w_e_rf));
    adpll_edge_sync u_sync_gen (.clk(i_clk), .rst(i_rst), .din(bus.i_gen), .pulse(w_e_gen));

    meas_state_t        r_meas;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   r_err;
    logic               r_err_vld;
    logic               r_timeout;
    lock_state_t        r_lock_st;
    logic [c_good_w-1:0] r_good;
    logic [c_bad_w-1:0]  r_bad;

    logic               w_emit;
    logic               w_tmo;
    err_sign_t          w_sign;
    logic [CNT_W-1:0]   w_mag;
    logic [CNT_W-1:0]   w_mag_sat;
    logic [CNT_W-1:0]   w_err;
    logic               w_in_win;

    // Decode of this cycle's measurement outcome; shared by both machines so
    // lock can change on the same cycle the corresponding strobe appears.
    always_comb begin
        w_emit = 1'b0;
        w_tmo  = 1'b0;
        w_sign = ERR_GEN_LAGS;
        w_mag  = r_cnt;
        unique case (r_meas)
            MEAS_IDLE: begin
                w_mag = '0;
                if (w_e_rf && w_e_gen) begin
                    w_emit = 1'b1;
                end
            end
            MEAS_WAIT_GEN: begin
                if (w_e_gen) begin
                    w_emit = 1'b1;
                end else if (w_e_rf || (r_cnt >= c_timeout)) begin
                    w_tmo = 1'b1;
                end
            end
            MEAS_WAIT_RF: begin
                w_sign = ERR_GEN_LEADS;
                if (w_e_rf) begin
                    w_emit = 1'b1;
                end else if (w_e_gen || (r_cnt >= c_timeout)) begin
                    w_tmo = 1'b1;
                end
            end
            default: begin
                w_mag = '0;
            end
        endcase
    end

    assign w_mag_sat = (w_mag > c_mag_max) ? c_mag_max : w_mag;
    assign w_err     = (w_sign == ERR_GEN_LEADS) ? -w_mag_sat : w_mag_sat;
    assign w_in_win  = (w_mag_sat <= c_window);

    // Measurement machine. A closing pulse that coincides with a new opening
    // pulse of the same kind restarts the count in the same waiting state.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_meas    <= MEAS_IDLE;
            r_cnt     <= '0;
            r_err     <= '0;
            r_err_vld <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_err_vld <= w_emit;
            r_timeout <= w_tmo;
            if (w_emit) begin
                r_err <= w_err;
            end
            unique case (r_meas)
                MEAS_IDLE: begin
                    if (w_e_rf && !w_e_gen) begin
                        r_cnt  <= c_one;
                        r_meas <= MEAS_WAIT_GEN;
                    end else if (w_e_gen && !w_e_rf) begin
                        r_cnt  <= c_one;
                        r_meas <= MEAS_WAIT_RF;
                    end
                end
                MEAS_WAIT_GEN: begin
                    if (w_e_gen) begin
                        r_cnt <= c_one;
                        if (!w_e_rf) begin
                            r_meas <= MEAS_IDLE;
                        end
                    end else if (w_e_rf) begin
                        r_cnt <= c_one;
                    end else if (r_cnt >= c_timeout) begin
                        r_meas <= MEAS_IDLE;
                    end else begin
                        r_cnt <= r_cnt + c_one;
                    end
                end
                MEAS_WAIT_RF: begin
                    if (w_e_rf) begin
                        r_cnt <= c_one;
                        if (!w_e_gen) begin
                            r_meas <= MEAS_IDLE;
                        end
                    end else if (w_e_gen) begin
                        r_cnt <= c_one;
                    end else if (r_cnt >= c_timeout) begin
                        r_meas <= MEAS_IDLE;
                    end else begin
                        r_cnt <= r_cnt + c_one;
                    end
                end
                default: begin
                    r_meas <= MEAS_IDLE;
                end
            endcase
        end
    end

    // Lock machine. A timeout strobe outranks any measurement closing on the
    // following cycle.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_lock_st <= LOCK_UNLOCKED;
            r_good    <= '0;
            r_bad     <= '0;
        end else if (r_timeout) begin
            r_lock_st <= LOCK_UNLOCKED;
            r_good    <= '0;
            r_bad     <= '0;
        end else if (w_emit) begin
            case (r_lock_st)
                LOCK_UNLOCKED: begin
                    if (!w_in_win) begin
                        r_good <= '0;
                    end else if (r_good >= c_good_last) begin
                        r_lock_st <= LOCK_LOCKED;
                        r_good    <= '0;
                        r_bad     <= '0;
                    end else begin
                        r_good <= r_good + 1'b1;
                    end
                end
                LOCK_LOCKED: begin
                    if (w_in_win) begin
                        r_bad <= '0;
                    end else if (r_bad >= c_bad_last) begin
                        r_lock_st <= LOCK_UNLOCKED;
                        r_good    <= '0;
                        r_bad     <= '0;
                    end else begin
                        r_bad <= r_bad + 1'b1;
                    end
                end
            endcase
        end
    end

    assign bus.o_err     = r_err;
    assign bus.o_err_vld = r_err_vld;
    assign bus.o_timeout = r_timeout;
    assign bus.o_lock    = (r_lock_st == LOCK_LOCKED);
endmodule
`default_nettype wire

// File: tb/tb_adpll_lock_det.sv
`default_nettype none
// ============================================================================
// Module      : tb_adpll_lock_det
// Description : Self-checking bench for adpll_lock_det. A reference model
//               works on the cycle numbers of the rising edges the bench
//               drives; predicted strobes go into a queue that a separate
//               monitor drains against the DUT outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adpll_lock_det;
    import adpll_pkg::*;

    localparam int WINDOW     = 2;
    localparam int LOCK_CNT   = 16;
    localparam int UNLOCK_CNT = 4;
    localparam int TIMEOUT    = 64;
    // Edge driven on cycle k shows up as a registered strobe on cycle k+4
    // (3 cycles of conditioning plus the registered emit).
    localparam int LAT        = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    adpll_lock_det_if #(.CNT_W(8)) bus ();

    adpll_lock_det #(
        .CNT_W      (8),
        .WINDOW     (WINDOW),
        .LOCK_CNT   (LOCK_CNT),
        .UNLOCK_CNT (UNLOCK_CNT),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .i_clk (clk),
        .i_rst (rst_n),
        .bus   (bus)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit is_tmo;
        int stamp;
        int err;
        bit lock;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_tests  = 0;
    int   n_fail   = 0;
    int   last_err = 0;
    bit   chk_drop = 1'b0;

    // Reference model state: which edge opened the current measurement
    // (0 none, 1 rf, 2 gen) and on which cycle.
    int   m_open     = 0;
    int   m_start    = 0;
    int   m_good     = 0;
    int   m_bad      = 0;
    bit   m_locked   = 1'b0;
    bit   m_tmo_prev = 1'b0;
    bit   rf_l       = 1'b0;
    bit   gen_l      = 1'b0;

    function automatic void model_reset();
        m_open     = 0;
        m_start    = 0;
        m_good     = 0;
        m_bad      = 0;
        m_locked   = 1'b0;
        m_tmo_prev = 1'b0;
    endfunction

    function automatic void model_step(int e, bit er, bit eg);
        bit emit = 1'b0;
        bit tmo  = 1'b0;
        int err  = 0;
        int d    = e - m_start;
        case (m_open)
            0: begin
                if (er && eg) begin emit = 1'b1; err = 0; end
                else if (er) begin m_open = 1; m_start = e; end
                else if (eg) begin m_open = 2; m_start = e; end
            end
            1: begin
                if (eg) begin
                    emit = 1'b1; err = d;
                    if (er) m_start = e; else m_open = 0;
                end else if (er) begin
                    tmo = 1'b1; m_start = e;
                end else if (d >= TIMEOUT) begin
                    tmo = 1'b1; m_open = 0;
                end
            end
            default: begin
                if (er) begin
                    emit = 1'b1; err = -d;
                    if (eg) m_start = e; else m_open = 0;
                end else if (eg) begin
                    tmo = 1'b1; m_start = e;
                end else if (d >= TIMEOUT) begin
                    tmo = 1'b1; m_open = 0;
                end
            end
        endcase
        if (m_tmo_prev) begin
            m_locked = 1'b0; m_good = 0; m_bad = 0;
        end else if (emit) begin
            if (!m_locked) begin
                if (err <= WINDOW && err >= -WINDOW) begin
                    m_good++;
                    if (m_good >= LOCK_CNT) begin m_locked = 1'b1; m_good = 0; m_bad = 0; end
                end else m_good = 0;
            end else begin
                if (err > WINDOW || err < -WINDOW) begin
                    m_bad++;
                    if (m_bad >= UNLOCK_CNT) begin m_locked = 1'b0; m_good = 0; m_bad = 0; end
                end else m_bad = 0;
            end
        end
        if (emit) exp_q.push_back('{is_tmo: 1'b0, stamp: e + LAT, err: err, lock: m_locked});
        if (tmo)  exp_q.push_back('{is_tmo: 1'b1, stamp: e + LAT, err: 0, lock: 1'b0});
        m_tmo_prev = tmo;
    endfunction

    task automatic step(input bit nrf, input bit ngen);
        bit er;
        bit eg;
        @(negedge clk);
        er = nrf && !rf_l;
        eg = ngen && !gen_l;
        rf_l = nrf;
        gen_l = ngen;
        bus.i_rf  = nrf;
        bus.i_gen = ngen;
        model_step(cyc, er, eg);
    endtask

    // One reference period: rf high on cycles [8,14), gen shifted by lag.
    task automatic run_period(input int p, input int lag, input bit no_rf, input bit no_gen);
        for (int c = 0; c < p; c++) begin
            step(!no_rf && c >= 8 && c < 14, !no_gen && c >= 8 + lag && c < 14 + lag);
        end
    endtask

    task automatic check_zero(input string name, input logic [7:0] act);
        n_tests++;
        if (act !== 8'd0) begin
            n_fail++;
            $display("FAIL %s: got %0h, required 0", name, act);
        end
    endtask

    // Reset for ncyc clock edges; inputs may toggle early but are low for
    // the last cycles so no edge is pending at release.
    task automatic do_reset(input int ncyc, input bit toggle, input bit check);
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        chk_drop = 1'b0;
        for (int i = 0; i < ncyc - 1; i++) begin
            @(negedge clk);
            if (toggle && i < ncyc - 3) begin
                bus.i_rf  = 1'($urandom);
                bus.i_gen = 1'($urandom);
            end else begin
                bus.i_rf  = 1'b0;
                bus.i_gen = 1'b0;
            end
        end
        if (check) begin
            check_zero("reset_err", bus.o_err);
            check_zero("reset_err_vld", {7'd0, bus.o_err_vld});
            check_zero("reset_lock", {7'd0, bus.o_lock});
            check_zero("reset_timeout", {7'd0, bus.o_timeout});
        end
        @(negedge clk);
        bus.i_rf  = 1'b0;
        bus.i_gen = 1'b0;
        rf_l      = 1'b0;
        gen_l     = 1'b0;
        last_err  = 0;
        rst_n     = 1'b1;
    endtask

    // Monitor: every strobe must match the head of the queue on the
    // predicted cycle; between strobes o_err must hold.
    always @(negedge clk) begin
        if (rst_n) begin
            if (chk_drop) begin
                chk_drop = 1'b0;
                n_tests++;
                if (bus.o_lock !== 1'b0) begin
                    n_fail++;
                    $display("FAIL lock_after_timeout: o_lock=%0b, required 0 (cycle %0d)", bus.o_lock, cyc);
                end
            end
            if (bus.o_err_vld === 1'b1 || bus.o_timeout === 1'b1) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_strobe: vld=%0b timeout=%0b err=%0d at cycle %0d, required no strobe",
                             bus.o_err_vld, bus.o_timeout, $signed(bus.o_err), cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (bus.o_timeout !== mon_e.is_tmo ||
                        bus.o_err_vld !== (mon_e.is_tmo ? 1'b0 : 1'b1) ||
                        mon_e.stamp != cyc ||
                        (!mon_e.is_tmo && ($signed(bus.o_err) != mon_e.err || bus.o_lock !== mon_e.lock))) begin
                        n_fail++;
                        $display("FAIL strobe: got vld=%0b tmo=%0b err=%0d lock=%0b cycle=%0d, required tmo=%0b err=%0d lock=%0b cycle=%0d",
                                 bus.o_err_vld, bus.o_timeout, $signed(bus.o_err), bus.o_lock, cyc,
                                 mon_e.is_tmo, mon_e.err, mon_e.lock, mon_e.stamp);
                    end
                    if (mon_e.is_tmo) chk_drop = 1'b1;
                    else last_err = mon_e.err;
                end
            end else begin
                n_tests++;
                if ($signed(bus.o_err) != last_err) begin
                    n_fail++;
                    $display("FAIL err_hold: o_err=%0d, required %0d (cycle %0d)", $signed(bus.o_err), last_err, cyc);
                end
            end
            if (exp_q.size() > 0 && exp_q[0].stamp < cyc) begin
                n_tests++;
                n_fail++;
                $display("FAIL missing_strobe: no strobe observed, required tmo=%0b err=%0d at cycle %0d",
                         exp_q[0].is_tmo, exp_q[0].err, exp_q[0].stamp);
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        int p;
        int lag;
        bus.i_rf  = 1'b0;
        bus.i_gen = 1'b0;

        do_reset(5, 1'b1, 1'b1);
        repeat (4) step(1'b0, 1'b0);

        repeat (6)  run_period(32, 3, 1'b0, 1'b0);   // +3, out of window
        repeat (16) run_period(32, 1, 1'b0, 1'b0);   // lock on 16th strobe
        repeat (4)  run_period(32, 5, 1'b0, 1'b0);   // unlock on 4th strobe
        repeat (16) run_period(32, 0, 1'b0, 1'b0);   // coincident edges, relock
        repeat (2) begin
            repeat (3) run_period(32, 5, 1'b0, 1'b0);
            run_period(32, 1, 1'b0, 1'b0);           // lock holds
        end
        repeat (3)  run_period(32, -2, 1'b0, 1'b0);  // gen leads: -2
        repeat (2)  run_period(32, 0, 1'b0, 1'b0);
        repeat (2)  run_period(32, 0, 1'b0, 1'b1);   // gen stops: timeouts
        repeat (2)  run_period(32, 1, 1'b0, 1'b0);
        run_period(100, 0, 1'b0, 1'b1);              // silence: counter timeout

        // Reset while waiting for gen, then clean pairs.
        for (int c = 0; c < 20; c++) step(c >= 8 && c < 14, 1'b0);
        do_reset(1, 1'b0, 1'b0);
        repeat (3) run_period(32, 2, 1'b0, 1'b0);

        repeat (60) begin
            p   = $urandom_range(24, 48);
            lag = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 14) - 7 : $urandom_range(0, 6) - 3;
            run_period(p, lag, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
        end

        for (int i = 0; i < 200 && exp_q.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d events still pending, required 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
